// File: rtl/clock_pkg.sv
// Shared helpers for the fractional clock generator: increment computation and
// channel-index sizing.
package clock_pkg;

   // Rounded phase increment for an NCO of the given width: round(desired/actual * 2^width).
   function automatic logic [63:0] frequency_to_increment(
      input logic [63:0] actual,
      input logic [63:0] desired,
      input int unsigned width
   );
      logic [127:0] scaled;
      logic [127:0] quotient;
      scaled   = ({64'd0, desired} << width) + {65'd0, actual[63:1]};
      quotient = scaled / {64'd0, actual};
      return quotient[63:0];
   endfunction

   function automatic int unsigned channel_index_width(input int unsigned channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/clock_nco_channel.sv
// One NCO channel: accumulator, active/shadow increment, registered outputs.
// Optional wrap counter under CLOCK_FRACTIONAL_GENERATOR_PERIOD_COUNT_EN.
module clock_nco_channel
   import clock_pkg::*;
#(
   parameter int unsigned          ACC_WIDTH         = 32,
   parameter logic [ACC_WIDTH-1:0] DEFAULT_INCREMENT =
      ACC_WIDTH'(frequency_to_increment(64'd50_000_000, 64'd16_000_000, ACC_WIDTH)),
   parameter int unsigned          COUNT_WIDTH       = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   resync,
   input  logic                   load,
   input  logic [ACC_WIDTH-1:0]   load_data,
   output logic                   pending,
   output logic                   clock_generated,
   output logic                   tick,
   output logic [COUNT_WIDTH-1:0] period_count
);

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] inc_q, inc_d;
   logic [ACC_WIDTH-1:0] shadow_q, shadow_d;
   logic                 pending_q, pending_d;
   logic                 clk_out_q, clk_out_d;
   logic                 tick_q, tick_d;
   logic [ACC_WIDTH:0]   sum;
   logic                 carry;
   logic                 apply;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      sum       = {1'b0, acc_q} + {1'b0, inc_q};
      carry     = sum[ACC_WIDTH] & enable & ~resync;
      acc_d     = acc_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      inc_d     = inc_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;

      if (resync) begin
         acc_d     = '0;
         clk_out_d = 1'b0;
      end else if (enable) begin
         acc_d     = sum[ACC_WIDTH-1:0];
         tick_d    = sum[ACC_WIDTH];
         clk_out_d = sum[ACC_WIDTH-1];
      end

      // A channel that is stopped (disabled or zero increment) has no period in
      // flight, so its shadow can be swapped in immediately without a glitch.
      apply = pending_q & (resync | ~enable | carry | (inc_q == '0));
      if (apply) begin
         inc_d     = shadow_q;
         pending_d = 1'b0;
      end

      if (load) begin
         shadow_d = load_data;
         if (resync) inc_d = load_data;
         else        pending_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q     <= '0;
         inc_q     <= DEFAULT_INCREMENT;
         shadow_q  <= DEFAULT_INCREMENT;
         pending_q <= 1'b0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         acc_q     <= acc_d;
         inc_q     <= inc_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign pending         = pending_q;
   assign clock_generated = clk_out_q;
   assign tick            = tick_q;

`ifdef CLOCK_FRACTIONAL_GENERATOR_PERIOD_COUNT_EN
   logic [COUNT_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (resync)     count_d = '0;
      else if (carry) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign period_count = count_q;
`else
   assign period_count = '0;
`endif

endmodule

// File: rtl/clock_fractional_generator.sv
// Multi-channel fractional clock generator: write decode, increment clamp and
// resync fan-out. Wrap counters enabled by CLOCK_FRACTIONAL_GENERATOR_PERIOD_COUNT_EN.
module clock_fractional_generator
   import clock_pkg::*;
#(
   parameter int unsigned          CHANNELS          = 2,
   parameter int unsigned          ACC_WIDTH         = 32,
   parameter logic [ACC_WIDTH-1:0] DEFAULT_INCREMENT =
      ACC_WIDTH'(frequency_to_increment(64'd50_000_000, 64'd16_000_000, ACC_WIDTH)),
   parameter int unsigned          COUNT_WIDTH       = 16
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [CHANNELS-1:0]                   channel_enable,
   input  logic                                  resync,
   input  logic                                  increment_load,
   input  logic [channel_index_width(CHANNELS)-1:0] increment_channel,
   input  logic [ACC_WIDTH-1:0]                  increment_data,
   output logic [CHANNELS-1:0]                   increment_pending,
   output logic [CHANNELS-1:0]                   clock_generated,
   output logic [CHANNELS-1:0]                   tick,
   output logic [CHANNELS*COUNT_WIDTH-1:0]       period_count
);

   localparam int unsigned CH_IDX_W = channel_index_width(CHANNELS);
   localparam logic [ACC_WIDTH-1:0] MAX_INCREMENT = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic [ACC_WIDTH-1:0] load_data;
   logic [CHANNELS-1:0]  load_sel;

   // Out-of-range channel indices match no slot and are dropped silently.
   always_comb begin
      load_data = (increment_data > MAX_INCREMENT) ? MAX_INCREMENT : increment_data;
      load_sel  = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         load_sel[ch] = increment_load && (increment_channel == CH_IDX_W'(ch));
      end
   end

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
      clock_nco_channel #(
         .ACC_WIDTH         (ACC_WIDTH),
         .DEFAULT_INCREMENT (DEFAULT_INCREMENT),
         .COUNT_WIDTH       (COUNT_WIDTH)
      ) u_channel (
         .clock           (clock),
         .reset           (reset),
         .enable          (channel_enable[ch]),
         .resync          (resync),
         .load            (load_sel[ch]),
         .load_data       (load_data),
         .pending         (increment_pending[ch]),
         .clock_generated (clock_generated[ch]),
         .tick            (tick[ch]),
         .period_count    (period_count[ch*COUNT_WIDTH +: COUNT_WIDTH])
      );
   end

endmodule
